// File: rtl/top.sv
// rtl/top.sv - 35-input majority voter built on a carry-save population-count tree.
module top (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,  x8,  x9,
    input  logic       x10, x11, x12, x13, x14, x15, x16, x17, x18, x19,
    input  logic       x20, x21, x22, x23, x24, x25, x26, x27, x28, x29,
    input  logic       x30, x31, x32, x33, x34,
    output logic       y0,
    output logic [5:0] cnt,
    output logic       y0_q
);

    localparam int N_IN  = 35;
    localparam int N_CSA = N_IN - 2;
    localparam int N_OPS = N_IN + 2 * N_CSA;

    logic [N_IN-1:0] vote;
    logic            y0_d;

    assign vote = {x34, x33, x32, x31, x30, x29, x28, x27, x26, x25,
                   x24, x23, x22, x21, x20, x19, x18, x17, x16, x15,
                   x14, x13, x12, x11, x10, x9,  x8,  x7,  x6,  x5,
                   x4,  x3,  x2,  x1,  x0};

    // Operands form a FIFO pool: each 3:2 compressor consumes the three oldest
    // operands and appends its sum and shifted carry, leaving two for the final add.
    always_comb begin
        logic [5:0] ops [0:N_OPS-1];
        logic [5:0] a, b, c, maj;
        for (int i = 0; i < N_IN; i++) begin
            ops[i] = {5'd0, vote[i]};
        end
        for (int k = 0; k < N_CSA; k++) begin
            a   = ops[3*k];
            b   = ops[3*k+1];
            c   = ops[3*k+2];
            maj = (a & b) | (a & c) | (b & c);
            ops[N_IN+2*k]   = a ^ b ^ c;
            ops[N_IN+2*k+1] = {maj[4:0], 1'b0};
        end
        cnt = ops[N_OPS-2] + ops[N_OPS-1];
    end

    assign y0   = (cnt >= 6'd18);
    assign y0_d = y0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_q <= 1'b0;
        end else begin
            y0_q <= y0_d;
        end
    end

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - self-checking bench for the 35-input majority voter.
module tb_top;

    logic        clk;
    logic        rst_n;
    logic [34:0] vec;
    logic        x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,  x8,  x9;
    logic        x10, x11, x12, x13, x14, x15, x16, x17, x18, x19;
    logic        x20, x21, x22, x23, x24, x25, x26, x27, x28, x29;
    logic        x30, x31, x32, x33, x34;
    logic        y0;
    logic [5:0]  cnt;
    logic        y0_q;

    int n_vec;
    int n_checks;
    int n_fail;

    assign {x34, x33, x32, x31, x30, x29, x28, x27, x26, x25,
            x24, x23, x22, x21, x20, x19, x18, x17, x16, x15,
            x14, x13, x12, x11, x10, x9,  x8,  x7,  x6,  x5,
            x4,  x3,  x2,  x1,  x0} = vec;

    top dut (
        .clk(clk), .rst_n(rst_n),
        .x0(x0),   .x1(x1),   .x2(x2),   .x3(x3),   .x4(x4),
        .x5(x5),   .x6(x6),   .x7(x7),   .x8(x8),   .x9(x9),
        .x10(x10), .x11(x11), .x12(x12), .x13(x13), .x14(x14),
        .x15(x15), .x16(x16), .x17(x17), .x18(x18), .x19(x19),
        .x20(x20), .x21(x21), .x22(x22), .x23(x23), .x24(x24),
        .x25(x25), .x26(x26), .x27(x27), .x28(x28), .x29(x29),
        .x30(x30), .x31(x31), .x32(x32), .x33(x33), .x34(x34),
        .y0(y0), .cnt(cnt), .y0_q(y0_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int weight(input logic [34:0] v);
        int w = 0;
        for (int i = 0; i < 35; i++) w += (v[i] === 1'b1) ? 1 : 0;
        return w;
    endfunction

    // Majority means strictly more ones than zeros among the 35 voters.
    function automatic logic majority(input logic [34:0] v);
        return (weight(v) > 35 - weight(v));
    endfunction

    function automatic logic [34:0] vec_of_weight(input int k);
        logic [34:0] v = '0;
        while (weight(v) < k) v[$urandom_range(34, 0)] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s vec=%h weight=%0d observed=%0d expected=%0d",
                   tag, vec, weight(vec), obs, exp);
        end
    endtask

    task automatic apply_comb(input logic [34:0] v);
        vec = v;
        n_vec++;
        #1;
        check("cnt", {26'd0, cnt}, weight(v));
        check("y0",  {31'd0, y0},  {31'd0, majority(v)});
    endtask

    initial begin
        logic [34:0] v;
        logic        exp_q;
        n_vec = 0; n_checks = 0; n_fail = 0;
        rst_n = 1'b0;
        vec   = '0;

        #2;
        check("reset_y0_q", {31'd0, y0_q}, 32'd0);
        apply_comb(35'd0);
        check("zero_cnt", {26'd0, cnt}, 32'd0);
        apply_comb(35'h0_0001_FFFF);
        check("w17_y0", {31'd0, y0}, 32'd0);
        apply_comb(35'h7_FFFE_0000);
        check("w18_y0", {31'd0, y0}, 32'd1);
        apply_comb({35{1'b1}});
        check("all_cnt", {26'd0, cnt}, 32'd35);

        // Reset sequence: held low across a clock edge with 20 ones applied.
        apply_comb(35'h0_000F_FFFF);
        @(posedge clk); #1;
        check("rst_hold_y0_q", {31'd0, y0_q}, 32'd0);
        check("rst_hold_y0",   {31'd0, y0},   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_y0_q", {31'd0, y0_q}, 32'd1);
        apply_comb(35'h0_0000_03FF);
        check("drop_y0_q_held", {31'd0, y0_q}, 32'd1);
        @(posedge clk); #1;
        check("drop_y0_q", {31'd0, y0_q}, 32'd0);

        // Asynchronous assertion between edges.
        apply_comb({35{1'b1}});
        @(posedge clk); #1;
        check("pre_async_y0_q", {31'd0, y0_q}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_y0_q", {31'd0, y0_q}, 32'd0);
        check("async_cnt",  {26'd0, cnt},  32'd35);
        @(negedge clk);
        rst_n = 1'b1;

        // Random sweeps, alternating uniform bits and weights near the threshold.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i % 2 == 0) v = {$urandom(), $urandom()} & 35'h7_FFFF_FFFF;
            else            v = vec_of_weight($urandom_range(19, 16));
            apply_comb(v);
            exp_q = majority(v);
            @(posedge clk); #1;
            check("y0_q", {31'd0, y0_q}, {31'd0, exp_q});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have no parameters; the input count is fixed at 35 and the threshold is fixed at 18.
REQ-002 SHALL provide port `clk`, input, 1 bit: the single clock; rising edge active.
REQ-003 SHALL provide port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide ports `x0` .. `x34`, input, 1 bit each: 35 scalar voter inputs, where `x0` is the LSB of the vote vector.
REQ-005 SHALL provide port `y0`, output, 1 bit: combinational majority of `x0`..`x34`.
REQ-006 SHALL provide port `cnt`, output, 6 bits: combinational population count of `x0`..`x34`, range 0..35.
REQ-007 SHALL provide port `y0_q`, output, 1 bit: `y0` registered on `clk`.
REQ-008 SHALL leave the `y0` and `cnt` paths with no dependence on `clk` or `rst_n`, so an instantiation with `clk`/`rst_n` unconnected still yields correct `y0` and `cnt`.

Function
REQ-009 SHALL drive `y0` = 1 when at least 18 of the 35 inputs are 1, and 0 otherwise.
REQ-010 SHALL keep `y0` purely combinational: zero cycle latency, no latches, and settling well within 10 ns in zero-delay simulation.
REQ-011 SHALL make `y0` a symmetric function: any permutation of the inputs gives the same output.
REQ-012 SHALL treat no input combination as a tie, since 35 is odd.
REQ-013 SHALL compute `cnt` as an unsigned sum of the 35 bits in 6 bits, with no overflow (maximum 35 < 64).
REQ-014 SHALL build `cnt` and `y0` from a full-adder/half-adder compression tree (carry-save reduction followed by a final 6-bit add).
REQ-015 SHALL derive `y0` from the same count result as `cnt`, specifically the comparison `cnt >= 18`.
REQ-016 SHALL guarantee that `y0` and `cnt` are never mutually inconsistent for settled inputs.
REQ-017 SHALL capture `y0` into `y0_q` on each rising edge of `clk` while `rst_n` = 1.
REQ-018 SHALL give `y0_q` exactly one cycle of latency relative to inputs that are stable at the rising edge.
REQ-019 SHALL make `y0`, `cnt` and `y0_q` depend only on input values; there is no other state or mode.
REQ-020 SHALL add no handshake; the inputs are sampled continuously.

Reset
REQ-021 SHALL force `y0_q` to 0 immediately (asynchronously) whenever `rst_n` = 0, independent of `clk`.
REQ-022 SHALL hold `y0_q` at 0 for as long as `rst_n` remains low.
REQ-023 SHALL, on release (`rst_n` 0->1), update `y0_q` only at the first rising `clk` edge after release.
REQ-024 SHALL keep `y0` and `cnt` unaffected by reset; they track the inputs during reset.
REQ-025 SHALL ensure that asserting reset mid-operation causes no glitch on `y0` or `cnt`.

Verification
REQ-026 SHALL pass: all inputs 0 -> `cnt` = 0, `y0` = 0.
REQ-027 SHALL pass: exactly 17 inputs 1 (`x0`..`x16`) -> `cnt` = 17, `y0` = 0.
REQ-028 SHALL pass: exactly 18 inputs 1 (`x17`..`x34`) -> `cnt` = 18, `y0` = 1.
REQ-029 SHALL pass: all 35 inputs 1 -> `cnt` = 35, `y0` = 1.
REQ-030 SHALL pass the reset sequence: `rst_n` = 0 with 20 inputs 1 -> `y0_q` = 0 and `y0` = 1; release `rst_n`, one `clk` edge -> `y0_q` = 1; then drop to 10 ones -> `y0` = 0 immediately and `y0_q` = 0 after the next edge.
REQ-031 SHALL pass random and weighted-random sweeps (Hamming weights 16..19 emphasised) where every vector is checked for `y0` == (popcount >= 18) and `cnt` == popcount.
REQ-032 SHALL report any mismatch with the vector, its Hamming weight, the DUT output and the expected value.
